// File: rtl/b8_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | b8_mem_pkg: opcodes, load widths, store-done code and FSM states.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package b8_mem_pkg;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] WRITE_DONE_DEFAULT = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } mem_state_e;
endpackage
`default_nettype wire

// File: rtl/load_align_way1.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_align_way1: shifts RAM data to the byte offset and extends it.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module load_align_way1
    import b8_mem_pkg::*;
(
    input  logic [63:0] data_i,
    input  logic [2:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [63:0] result_o
);
    logic [63:0] shifted;

    assign shifted = data_i >> {offset_i, 3'b000};

    always_comb begin
        result_o = 64'd0;
        case (funct3_i)
            F3_LB:   result_o = {{56{shifted[7]}},  shifted[7:0]};
            F3_LH:   result_o = {{48{shifted[15]}}, shifted[15:0]};
            F3_LW:   result_o = {{32{shifted[31]}}, shifted[31:0]};
            F3_LD:   result_o = shifted;
            F3_LBU:  result_o = {56'd0, shifted[7:0]};
            F3_LHU:  result_o = {48'd0, shifted[15:0]};
            F3_LWU:  result_o = {32'd0, shifted[31:0]};
            default: result_o = 64'd0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/mem_access_way1.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_access_way1: single-issue load/store stage with writeback reg.   |
// | Optional trace ports under DEBUG_TRACE_EN.  Revision: 1.0            |
// +----------------------------------------------------------------------+
module mem_access_way1
    import b8_mem_pkg::*;
#(
    parameter logic [2:0] WRITE_DONE = WRITE_DONE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        rdWriteEnable_i,
    input  logic [4:0]  rdAddr_i,
    input  logic [63:0] rdData_i,
    input  logic [1:0]  way1_pID_i,
    input  logic [6:0]  opCode_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] readAddr_i,
    input  logic [31:0] writeAddr_i,
    input  logic [63:0] writeData_i,
    input  logic [3:0]  writeMask_i,
`ifdef DEBUG_TRACE_EN
    input  logic [31:0] instAddr_i,
    input  logic [31:0] inst_i,
    output logic [31:0] instAddr_o,
    output logic [31:0] inst_o,
`endif
    output logic        memReadEn_o,
    output logic        memWriteEn_o,
    output logic [31:0] memAddr_o,
    output logic [63:0] memWriteData_o,
    output logic [3:0]  memWriteMask_o,
    input  logic [63:0] memReadData_i,
    input  logic        dataOk_i,
    input  logic [2:0]  writeState_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        rdWriteEnable_o,
    output logic [4:0]  rdAddr_o,
    output logic [63:0] rdData_o,
    output logic [1:0]  way1_pID_o
);
    mem_state_e  state_q, state_d;
    logic        accept;
    logic        lat_we_q;
    logic [4:0]  lat_rd_q;
    logic [1:0]  lat_pid_q;
    logic [2:0]  lat_f3_q;
    logic [31:0] lat_addr_q;
    logic [63:0] lat_wdata_q;
    logic [3:0]  lat_wmask_q;
    logic [63:0] load_data;
    logic        cmp_d, cmp_we_d;
    logic [4:0]  cmp_rd_d;
    logic [63:0] cmp_data_d;
    logic [1:0]  cmp_pid_d;
    logic        valid_q, we_q;
    logic [4:0]  rd_q;
    logic [63:0] data_q;
    logic [1:0]  pid_q;

    // Reset also blocks acceptance so nothing sneaks in while it is held.
    assign ready_o = ~reset && (state_q == IDLE) && (~valid_q || ready_i);
    assign accept  = valid_i && ready_o;

    load_align_way1 u_align (
        .data_i   (memReadData_i),
        .offset_i (lat_addr_q[2:0]),
        .funct3_i (lat_f3_q),
        .result_o (load_data)
    );

    always_comb begin
        state_d    = state_q;
        cmp_d      = 1'b0;
        cmp_we_d   = 1'b0;
        cmp_rd_d   = 5'd0;
        cmp_data_d = 64'd0;
        cmp_pid_d  = 2'd0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (opCode_i == OP_LOAD) begin
                        state_d = READ;
                    end else if (opCode_i == OP_STORE) begin
                        state_d = WRITE;
                    end else begin
                        cmp_d      = 1'b1;
                        cmp_we_d   = rdWriteEnable_i;
                        cmp_rd_d   = rdAddr_i;
                        cmp_data_d = rdData_i;
                        cmp_pid_d  = way1_pID_i;
                    end
                end
            end
            READ: begin
                if (dataOk_i) begin
                    state_d    = IDLE;
                    cmp_d      = 1'b1;
                    cmp_we_d   = lat_we_q;
                    cmp_rd_d   = lat_rd_q;
                    cmp_data_d = load_data;
                    cmp_pid_d  = lat_pid_q;
                end
            end
            WRITE: begin
                if (writeState_i == WRITE_DONE) begin
                    state_d   = IDLE;
                    cmp_d     = 1'b1;
                    cmp_rd_d  = lat_rd_q;
                    cmp_pid_d = lat_pid_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lat_we_q    <= 1'b0;
            lat_rd_q    <= 5'd0;
            lat_pid_q   <= 2'd0;
            lat_f3_q    <= 3'd0;
            lat_addr_q  <= 32'd0;
            lat_wdata_q <= 64'd0;
            lat_wmask_q <= 4'd0;
            valid_q     <= 1'b0;
            we_q        <= 1'b0;
            rd_q        <= 5'd0;
            data_q      <= 64'd0;
            pid_q       <= 2'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                lat_we_q    <= rdWriteEnable_i;
                lat_rd_q    <= rdAddr_i;
                lat_pid_q   <= way1_pID_i;
                lat_f3_q    <= funct3_i;
                lat_addr_q  <= (opCode_i == OP_STORE) ? writeAddr_i : readAddr_i;
                lat_wdata_q <= writeData_i;
                lat_wmask_q <= writeMask_i;
            end
            // A new completion wins over a same-cycle drain.
            if (cmp_d) begin
                valid_q <= 1'b1;
                we_q    <= cmp_we_d;
                rd_q    <= cmp_rd_d;
                data_q  <= cmp_data_d;
                pid_q   <= cmp_pid_d;
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef DEBUG_TRACE_EN
    logic [31:0] lat_iaddr_q, lat_inst_q, iaddr_q, inst_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_iaddr_q <= 32'd0;
            lat_inst_q  <= 32'd0;
            iaddr_q     <= 32'd0;
            inst_q      <= 32'd0;
        end else begin
            if (accept) begin
                lat_iaddr_q <= instAddr_i;
                lat_inst_q  <= inst_i;
            end
            if (cmp_d) begin
                iaddr_q <= (state_q == IDLE) ? instAddr_i : lat_iaddr_q;
                inst_q  <= (state_q == IDLE) ? inst_i : lat_inst_q;
            end
        end
    end

    assign instAddr_o = iaddr_q;
    assign inst_o     = inst_q;
`endif

    assign memReadEn_o     = (state_q == READ);
    assign memWriteEn_o    = (state_q == WRITE);
    assign memAddr_o       = (state_q == IDLE) ? 32'd0 : lat_addr_q;
    assign memWriteData_o  = (state_q == WRITE) ? lat_wdata_q : 64'd0;
    assign memWriteMask_o  = (state_q == WRITE) ? lat_wmask_q : 4'd0;
    assign valid_o         = valid_q;
    assign rdWriteEnable_o = we_q;
    assign rdAddr_o        = rd_q;
    assign rdData_o        = data_q;
    assign way1_pID_o      = pid_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_access_way1.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_access_way1: vector table, directed corners, random traffic.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_access_way1;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_i = 1'b0, ready_i = 1'b1, rdWriteEnable_i = 1'b0;
    logic [4:0]  rdAddr_i = '0;
    logic [63:0] rdData_i = '0, writeData_i = '0, memReadData_i = '0;
    logic [1:0]  way1_pID_i = '0;
    logic [6:0]  opCode_i = '0;
    logic [2:0]  funct3_i = '0, writeState_i = '0;
    logic [31:0] readAddr_i = '0, writeAddr_i = '0;
    logic [3:0]  writeMask_i = '0;
    logic        dataOk_i = 1'b0;
    logic        ready_o, memReadEn_o, memWriteEn_o, valid_o, rdWriteEnable_o;
    logic [31:0] memAddr_o;
    logic [63:0] memWriteData_o, rdData_o;
    logic [3:0]  memWriteMask_o;
    logic [4:0]  rdAddr_o;
    logic [1:0]  way1_pID_o;
`ifdef DEBUG_TRACE_EN
    logic [31:0] instAddr_i = '0, inst_i = '0, instAddr_o, inst_o;
`endif

    int total = 0;
    int bad = 0;

    mem_access_way1 dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
        .rdWriteEnable_i(rdWriteEnable_i), .rdAddr_i(rdAddr_i), .rdData_i(rdData_i),
        .way1_pID_i(way1_pID_i), .opCode_i(opCode_i), .funct3_i(funct3_i),
        .readAddr_i(readAddr_i), .writeAddr_i(writeAddr_i), .writeData_i(writeData_i),
        .writeMask_i(writeMask_i),
`ifdef DEBUG_TRACE_EN
        .instAddr_i(instAddr_i), .inst_i(inst_i), .instAddr_o(instAddr_o), .inst_o(inst_o),
`endif
        .memReadEn_o(memReadEn_o), .memWriteEn_o(memWriteEn_o), .memAddr_o(memAddr_o),
        .memWriteData_o(memWriteData_o), .memWriteMask_o(memWriteMask_o),
        .memReadData_i(memReadData_i), .dataOk_i(dataOk_i), .writeState_i(writeState_i),
        .valid_o(valid_o), .ready_i(ready_i), .rdWriteEnable_o(rdWriteEnable_o),
        .rdAddr_o(rdAddr_o), .rdData_o(rdData_o), .way1_pID_o(way1_pID_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [63:0] mem;
        logic [63:0] exp;
    } ld_vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference load: pick bytes from the addressed offset, then extend by width rule.
    function automatic logic [63:0] ref_load(input logic [63:0] d, input logic [31:0] a,
                                             input logic [2:0] f3);
        int nb;
        bit sgn;
        logic [63:0] v, m;
        v = d >> (8 * int'(a[2:0]));
        case (f3)
            3'd0: begin nb = 1; sgn = 1; end
            3'd1: begin nb = 2; sgn = 1; end
            3'd2: begin nb = 4; sgn = 1; end
            3'd3: begin nb = 8; sgn = 0; end
            3'd4: begin nb = 1; sgn = 0; end
            3'd5: begin nb = 2; sgn = 0; end
            3'd6: begin nb = 4; sgn = 0; end
            default: return 64'd0;
        endcase
        if (nb == 8) return v;
        m = (64'd1 << (8 * nb)) - 64'd1;
        v = v & m;
        if (sgn && v[8 * nb - 1]) v = v | ~m;
        return v;
    endfunction

    task automatic do_alu(input logic [63:0] data, input logic [4:0] rd,
                          input logic [1:0] pid, input logic we, input string nm);
        valid_i = 1'b1; opCode_i = 7'b0110011; rdData_i = data; rdAddr_i = rd;
        way1_pID_i = pid; rdWriteEnable_i = we;
        #1;
        chk({nm, " ready"}, ready_o, 1'b1);
        tick();
        valid_i = 1'b0;
        chk({nm, " valid"}, valid_o, 1'b1);
        chk({nm, " data"}, rdData_o, data);
        chk({nm, " rd"}, rdAddr_o, rd);
        chk({nm, " pid"}, way1_pID_o, pid);
        chk({nm, " we"}, rdWriteEnable_o, we);
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [63:0] mem,
                           input int dly, input logic [4:0] rd, input logic [1:0] pid,
                           input logic we, input logic [63:0] exp, input string nm);
        valid_i = 1'b1; opCode_i = 7'b0000011; funct3_i = f3; readAddr_i = addr;
        writeAddr_i = ~addr; rdAddr_i = rd; way1_pID_i = pid; rdWriteEnable_i = we;
        #1;
        chk({nm, " ready"}, ready_o, 1'b1);
        tick();
        valid_i = 1'b0; opCode_i = 7'd0; readAddr_i = 32'hDEAD_BEEF;
        for (int c = 0; c < dly; c++) begin
            #1;
            chk({nm, " rden"}, memReadEn_o, 1'b1);
            chk({nm, " wren"}, memWriteEn_o, 1'b0);
            chk({nm, " addr"}, memAddr_o, addr);
            chk({nm, " busy"}, ready_o, 1'b0);
            tick();
        end
        dataOk_i = 1'b1; memReadData_i = mem;
        #1;
        chk({nm, " rden last"}, memReadEn_o, 1'b1);
        tick();
        dataOk_i = 1'b0; memReadData_i = $urandom();
        chk({nm, " valid"}, valid_o, 1'b1);
        chk({nm, " data"}, rdData_o, exp);
        chk({nm, " rd"}, rdAddr_o, rd);
        chk({nm, " pid"}, way1_pID_o, pid);
        chk({nm, " we"}, rdWriteEnable_o, we);
        chk({nm, " idle rden"}, memReadEn_o, 1'b0);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [63:0] data, input logic [3:0] mask,
                            input logic [4:0] rd, input logic [1:0] pid, input string nm);
        valid_i = 1'b1; opCode_i = 7'b0100011; writeAddr_i = addr; readAddr_i = ~addr;
        writeData_i = data; writeMask_i = mask; rdAddr_i = rd; way1_pID_i = pid;
        rdWriteEnable_i = 1'b1; writeState_i = 3'd0;
        #1;
        chk({nm, " ready"}, ready_o, 1'b1);
        tick();
        valid_i = 1'b0; writeData_i = '0; writeMask_i = '0; writeAddr_i = '0;
        for (int s = 0; s < 8; s++) begin
            writeState_i = 3'(s);
            #1;
            chk({nm, " wren"}, memWriteEn_o, 1'b1);
            chk({nm, " rden"}, memReadEn_o, 1'b0);
            chk({nm, " addr"}, memAddr_o, addr);
            chk({nm, " wdata"}, memWriteData_o, data);
            chk({nm, " mask"}, memWriteMask_o, mask);
            chk({nm, " busy"}, ready_o, 1'b0);
            tick();
        end
        writeState_i = 3'd0;
        chk({nm, " valid"}, valid_o, 1'b1);
        chk({nm, " we"}, rdWriteEnable_o, 1'b0);
        chk({nm, " rd"}, rdAddr_o, rd);
        chk({nm, " pid"}, way1_pID_o, pid);
        chk({nm, " wren off"}, memWriteEn_o, 1'b0);
    endtask

    task automatic drain(input string nm);
        ready_i = 1'b1;
        tick();
        chk({nm, " drained"}, valid_o, 1'b0);
    endtask

    ld_vec_t vt[9];

    initial begin
        logic [63:0] held;
        vt[0] = '{3'd0, 32'h1003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80};
        vt[1] = '{3'd5, 32'h2006, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001};
        vt[2] = '{3'd2, 32'h1004, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321};
        vt[3] = '{3'd3, 32'h1000, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
        vt[4] = '{3'd4, 32'h1001, 64'h0000_0000_0000_F000, 64'h0000_0000_0000_00F0};
        vt[5] = '{3'd1, 32'h1002, 64'h0000_0000_7FFF_0000, 64'h0000_0000_0000_7FFF};
        vt[6] = '{3'd6, 32'h1000, 64'h1111_1111_F000_0001, 64'h0000_0000_F000_0001};
        vt[7] = '{3'd7, 32'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000};
        vt[8] = '{3'd0, 32'h1007, 64'h7F00_0000_0000_0000, 64'h0000_0000_0000_007F};

        tick();
        chk("rst valid", valid_o, 1'b0);
        chk("rst ready", ready_o, 1'b0);
        chk("rst rden", memReadEn_o, 1'b0);
        chk("rst wren", memWriteEn_o, 1'b0);
        chk("rst addr", memAddr_o, 32'd0);
        chk("rst data", rdData_o, 64'd0);
        reset = 1'b0;
        tick();

        do_alu(64'h1234, 5'd5, 2'd1, 1'b1, "alu");
        drain("alu");

        for (int i = 0; i < 9; i++) begin
            do_load(vt[i].addr, vt[i].f3, vt[i].mem, (i == 0) ? 3 : i % 3,
                    5'(i + 1), 2'(i), 1'b1, vt[i].exp, $sformatf("vec%0d", i));
            drain($sformatf("vec%0d", i));
        end

        do_store(32'h3000, 64'hCAFE_F00D_1234_5678, 4'b1010, 5'd9, 2'd3, "store");
        drain("store");

        // Writeback stall after a load: result must hold, no new acceptance.
        ready_i = 1'b0;
        do_load(32'h1003, 3'd0, 64'h0000_0000_8000_0000, 2, 5'd7, 2'd2, 1'b1,
                64'hFFFF_FFFF_FFFF_FF80, "hold");
        held = rdData_o;
        valid_i = 1'b1; opCode_i = 7'b0110011;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("hold valid", valid_o, 1'b1);
            chk("hold data", rdData_o, held);
            chk("hold ready", ready_o, 1'b0);
        end
        valid_i = 1'b0;
        drain("hold");

        // Drain and new completion in the same cycle.
        ready_i = 1'b0;
        do_alu(64'hAAAA, 5'd3, 2'd0, 1'b1, "b2b first");
        ready_i = 1'b1;
        do_alu(64'hBBBB, 5'd4, 2'd2, 1'b0, "b2b second");
        drain("b2b");

        dataOk_i = 1'b1; memReadData_i = 64'h55;
        tick();
        dataOk_i = 1'b0;
        chk("stray dataOk", valid_o, 1'b0);

        // Reset in the middle of a load.
        valid_i = 1'b1; opCode_i = 7'b0000011; funct3_i = 3'd3; readAddr_i = 32'h4000;
        tick();
        valid_i = 1'b0;
        tick();
        chk("pre-rst rden", memReadEn_o, 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst rden", memReadEn_o, 1'b0);
        chk("midrst addr", memAddr_o, 32'd0);
        chk("midrst ready", ready_o, 1'b0);
        chk("midrst valid", valid_o, 1'b0);
        chk("midrst data", rdData_o, 64'd0);
        chk("midrst rd", rdAddr_o, 5'd0);
        tick();
        reset = 1'b0;
        dataOk_i = 1'b1; memReadData_i = 64'h99;
        tick();
        dataOk_i = 1'b0;
        chk("post-rst ignore", valid_o, 1'b0);
        chk("post-rst rden", memReadEn_o, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int kind;
            logic [31:0] a;
            logic [63:0] d;
            logic [2:0] f;
            kind = int'($urandom_range(0, 2));
            a = $urandom();
            d = {$urandom(), $urandom()};
            f = 3'($urandom_range(0, 7));
            case (kind)
                0: do_alu(d, 5'($urandom()), 2'($urandom()), 1'($urandom()), "rnd alu");
                1: do_load(a, f, d, int'($urandom_range(0, 3)), 5'($urandom()), 2'($urandom()),
                           1'($urandom()), ref_load(d, a, f), $sformatf("rnd ld f3=%0d", f));
                default: do_store(a, d, 4'($urandom()), 5'($urandom()), 2'($urandom()), "rnd st");
            endcase
            drain("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
